// File: rtl/gpu_pixel_writer_pkg.sv
// Shared definitions for the pixel writer: screen geometry, coordinate and
// framebuffer widths, and a saturating increment helper for the clip counter.
package gpu_pixel_writer_pkg;

    localparam int WIDTH_BITS    = 9;     // enough bits for x in 0..511
    localparam int HEIGHT_BITS   = 8;     // enough bits for y in 0..255
    localparam int FB_SCREEN_W   = 320;
    localparam int FB_SCREEN_H   = 240;
    localparam int FB_ADDR_BITS  = 17;    // covers 320*240 = 76800 words
    localparam int FB_COLOR_BITS = 8;
    localparam int CLIP_CNT_BITS = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CLIP_CNT_BITS-1:0] sat_inc(input logic [CLIP_CNT_BITS-1:0] val);
        logic [CLIP_CNT_BITS-1:0] res;
        if (val == {CLIP_CNT_BITS{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(CLIP_CNT_BITS-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Parameterised synchronous circular FIFO. Full/empty flags are registered
// alongside the count so consumers see clean flop outputs.
module gpu_pixel_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and flags; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == CW'(0));
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/gpu_pixel_writer.sv
// Pixel stream consumer: clips off-screen pixels, converts (x, y) to a linear
// framebuffer address, queues the writes and issues them over req/ack.
import gpu_pixel_writer_pkg::*;

module gpu_pixel_writer #(
    parameter int SCREEN_W   = FB_SCREEN_W,
    parameter int SCREEN_H   = FB_SCREEN_H,
    parameter int COLOR_BITS = FB_COLOR_BITS,
    parameter int ADDR_BITS  = FB_ADDR_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [WIDTH_BITS-1:0]  x_i,
    input  logic [HEIGHT_BITS-1:0] y_i,
    input  logic [COLOR_BITS-1:0]  color_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [ADDR_BITS-1:0]   mem_addr_o,
    output logic [COLOR_BITS-1:0]  mem_data_o,
    output logic                   mem_req_o,
    input  logic                   mem_ack_i,
    output logic                   idle_o,
    output logic [15:0]            clip_cnt_o
);

    localparam int ENTRY_W = ADDR_BITS + COLOR_BITS;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WIDTH_BITS:0]  SCREEN_W_L = (WIDTH_BITS+1)'(SCREEN_W);
    localparam logic [HEIGHT_BITS:0] SCREEN_H_L = (HEIGHT_BITS+1)'(SCREEN_H);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 clip_s;
    logic                 accept_s;
    logic                 in_range_s;
    logic [ADDR_BITS-1:0] addr_s;
    logic [ENTRY_W-1:0]   fifo_rdata_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [CW-1:0]        fifo_count_s;
    logic [ADDR_BITS-1:0] mem_addr_r;
    logic [COLOR_BITS-1:0] mem_data_r;
    logic [15:0]          clip_cnt_r;
    logic                 mem_req_s;
    logic                 idle_s;

    assign ready_o    = !fifo_full_s;
    assign accept_s   = valid_i && ready_o;
    assign in_range_s = ({1'b0, x_i} < SCREEN_W_L) && ({1'b0, y_i} < SCREEN_H_L);
    assign push_s     = accept_s && in_range_s;
    assign clip_s     = accept_s && !in_range_s;
    assign addr_s     = ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(x_i);

    gpu_pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push_s),
        .wdata ({addr_s, color_i}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // FSM state register; reset abandons any pending write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and pop: load a new head when idle, or back-to-back on ack.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs, decoded from registered state only.
    always_comb begin
        mem_req_s = 1'b0;
        idle_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mem_req_s = 1'b0;
                idle_s    = (fifo_count_s == CW'(0));
            end
            ST_REQ: begin
                mem_req_s = 1'b1;
                idle_s    = 1'b0;
            end
            default: begin
                mem_req_s = 1'b0;
                idle_s    = 1'b0;
            end
        endcase
    end

    // Output address/data registers, loaded only when a head is popped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_addr_r <= {ADDR_BITS{1'b0}};
            mem_data_r <= {COLOR_BITS{1'b0}};
        end else if (pop_s) begin
            mem_addr_r <= fifo_rdata_s[ENTRY_W-1:COLOR_BITS];
            mem_data_r <= fifo_rdata_s[COLOR_BITS-1:0];
        end else begin
            mem_addr_r <= mem_addr_r;
            mem_data_r <= mem_data_r;
        end
    end

    // Saturating count of discarded off-screen pixels.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clip_cnt_r <= 16'h0000;
        end else if (clip_s) begin
            clip_cnt_r <= sat_inc(clip_cnt_r);
        end else begin
            clip_cnt_r <= clip_cnt_r;
        end
    end

    assign mem_addr_o = mem_addr_r;
    assign mem_data_o = mem_data_r;
    assign mem_req_o  = mem_req_s;
    assign idle_o     = idle_s;
    assign clip_cnt_o = clip_cnt_r;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed self-checking bench for gpu_pixel_writer. Inputs are driven 1ns
// after each rising edge and outputs are sampled at the same point.
module tb_gpu_pixel_writer;

    logic        tb_clk;
    logic        n_rst;
    logic [8:0]  x_i;
    logic [7:0]  y_i;
    logic [7:0]  color_i;
    logic        valid_i;
    logic        ready_o;
    logic [16:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        mem_req_o;
    logic        mem_ack_i;
    logic        idle_o;
    logic [15:0] clip_cnt_o;

    int checks_cnt;
    int errors_cnt;

    gpu_pixel_writer dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .x_i        (x_i),
        .y_i        (y_i),
        .color_i    (color_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_req_o  (mem_req_o),
        .mem_ack_i  (mem_ack_i),
        .idle_o     (idle_o),
        .clip_cnt_o (clip_cnt_o)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic drive_pix(input int px, input int py, input int pc);
        x_i     = 9'(px);
        y_i     = 8'(py);
        color_i = 8'(pc);
        valid_i = 1'b1;
    endtask

    // Stream n_pix pixels in raster order over a rectangle n_cols wide,
    // ack tied high; expects one write per cycle with no bubbles.
    task automatic run_stream(input string tag, input int n_pix, input int n_cols);
        int ea;
        mem_ack_i = 1'b1;
        for (int i = 0; i < n_pix; i++) begin
            drive_pix(i % n_cols, i / n_cols, 8'h40 + i);
            tick();
            if (i > 0) begin
                ea = ((i - 1) / n_cols) * 320 + ((i - 1) % n_cols);
                check_val({tag, "_req"}, 32'(mem_req_o), 32'd1);
                check_val({tag, "_addr"}, 32'(mem_addr_o), 32'(ea));
                check_val({tag, "_data"}, 32'(mem_data_o), 32'(8'h40 + i - 1));
            end
        end
        valid_i = 1'b0;
        tick();
        ea = ((n_pix - 1) / n_cols) * 320 + ((n_pix - 1) % n_cols);
        check_val({tag, "_last_addr"}, 32'(mem_addr_o), 32'(ea));
        check_val({tag, "_last_req"}, 32'(mem_req_o), 32'd1);
        tick();
        check_val({tag, "_idle"}, 32'(idle_o), 32'd1);
        check_val({tag, "_req_drop"}, 32'(mem_req_o), 32'd0);
        mem_ack_i = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        n_rst      = 1'b0;
        x_i        = 9'd0;
        y_i        = 8'd0;
        color_i    = 8'd0;
        valid_i    = 1'b0;
        mem_ack_i  = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_ready", 32'(ready_o), 32'd1);
        check_val("rst_req", 32'(mem_req_o), 32'd0);
        check_val("rst_addr", 32'(mem_addr_o), 32'd0);
        check_val("rst_data", 32'(mem_data_o), 32'd0);
        check_val("rst_idle", 32'(idle_o), 32'd1);
        check_val("rst_clip", 32'(clip_cnt_o), 32'd0);
        n_rst = 1'b1;
        tick();

        // Single pixel (10,5) with ack two cycles after req
        drive_pix(10, 5, 8'h3C);
        tick();
        valid_i = 1'b0;
        check_val("single_noreq_yet", 32'(mem_req_o), 32'd0);
        check_val("single_busy", 32'(idle_o), 32'd0);
        tick();
        check_val("single_req1", 32'(mem_req_o), 32'd1);
        check_val("single_addr1", 32'(mem_addr_o), 32'd1610);
        check_val("single_data1", 32'(mem_data_o), 32'h3C);
        tick();
        check_val("single_req2", 32'(mem_req_o), 32'd1);
        check_val("single_addr2", 32'(mem_addr_o), 32'd1610);
        mem_ack_i = 1'b1;
        #3;
        check_val("single_req3", 32'(mem_req_o), 32'd1);
        check_val("single_data3", 32'(mem_data_o), 32'h3C);
        tick();
        check_val("single_req_off", 32'(mem_req_o), 32'd0);
        check_val("single_idle", 32'(idle_o), 32'd1);
        mem_ack_i = 1'b0;

        // Stream of four pixels on row 0
        run_stream("stream", 4, 4);

        // Backpressure: ack low, valid held high
        mem_ack_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_val("bp_ready_hi", 32'(ready_o), 32'd1);
            drive_pix(k, 1, 8'h80 + k);
            tick();
        end
        check_val("bp_ready_lo", 32'(ready_o), 32'd0);
        drive_pix(5, 1, 8'h85);
        tick();
        tick();
        check_val("bp_ready_stay_lo", 32'(ready_o), 32'd0);
        check_val("bp_head_addr", 32'(mem_addr_o), 32'd320);
        check_val("bp_head_data", 32'(mem_data_o), 32'h80);
        valid_i   = 1'b0;
        mem_ack_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            if (k == 1) begin
                check_val("bp_ready_rise", 32'(ready_o), 32'd1);
            end
            check_val("bp_drain_req", 32'(mem_req_o), 32'd1);
            check_val("bp_drain_addr", 32'(mem_addr_o), 32'(320 + k));
            check_val("bp_drain_data", 32'(mem_data_o), 32'(8'h80 + k));
        end
        tick();
        check_val("bp_idle", 32'(idle_o), 32'd1);
        check_val("bp_req_off", 32'(mem_req_o), 32'd0);

        // Clipping and corner addresses
        drive_pix(320, 0, 8'h11);
        tick();
        drive_pix(0, 240, 8'h22);
        tick();
        valid_i = 1'b0;
        check_val("clip_noreq1", 32'(mem_req_o), 32'd0);
        tick();
        check_val("clip_noreq2", 32'(mem_req_o), 32'd0);
        check_val("clip_idle", 32'(idle_o), 32'd1);
        check_val("clip_cnt", 32'(clip_cnt_o), 32'd2);
        drive_pix(319, 239, 8'hA5);
        tick();
        valid_i = 1'b0;
        tick();
        check_val("corner_max_req", 32'(mem_req_o), 32'd1);
        check_val("corner_max_addr", 32'(mem_addr_o), 32'd76799);
        check_val("corner_max_data", 32'(mem_data_o), 32'hA5);
        tick();
        drive_pix(0, 0, 8'h5A);
        tick();
        valid_i = 1'b0;
        tick();
        check_val("corner_zero_req", 32'(mem_req_o), 32'd1);
        check_val("corner_zero_addr", 32'(mem_addr_o), 32'd0);
        check_val("corner_zero_data", 32'(mem_data_o), 32'h5A);
        tick();
        check_val("corner_idle", 32'(idle_o), 32'd1);

        // Reset while in REQ with three pixels queued
        mem_ack_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_pix(5 + k, 2, 8'hC0 + k);
            tick();
        end
        valid_i = 1'b0;
        check_val("mid_req_before", 32'(mem_req_o), 32'd1);
        check_val("mid_addr_before", 32'(mem_addr_o), 32'd645);
        n_rst = 1'b0;
        #1;
        check_val("mid_rst_req", 32'(mem_req_o), 32'd0);
        check_val("mid_rst_idle", 32'(idle_o), 32'd1);
        check_val("mid_rst_ready", 32'(ready_o), 32'd1);
        check_val("mid_rst_addr", 32'(mem_addr_o), 32'd0);
        check_val("mid_rst_clip", 32'(clip_cnt_o), 32'd0);
        tick();
        n_rst     = 1'b1;
        mem_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("post_rst_noreq", 32'(mem_req_o), 32'd0);
            check_val("post_rst_idle", 32'(idle_o), 32'd1);
        end
        mem_ack_i = 1'b0;

        // Rectangle (0,0)-(3,2) in raster order
        run_stream("rect", 12, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
